// File: rtl/logic_eval_pkg.sv
// Shared types and constants for the logic evaluator scheduler.
package logic_eval_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    RESP
  } state_t;

  // Width of one {a,b,c} evaluator vector.
  localparam int unsigned ABC_W = 3;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: picks the first requester at or after
// last_grant+1, wrapping. The pointer register lives in the parent.
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic                       en,
  input  logic [$clog2(NUM_REQ)-1:0] last_grant,
  output logic [NUM_REQ-1:0]         grant,
  output logic [$clog2(NUM_REQ)-1:0] grant_idx
);

  localparam int unsigned ID_W = $clog2(NUM_REQ);

  logic        found;
  int unsigned cand;

  // Scan offsets 1..NUM_REQ from the last winner; the first hit wins.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    cand      = 0;
    for (int unsigned off = 1; off <= NUM_REQ; off++) begin
      cand = (32'(last_grant) + off) % NUM_REQ;
      if (en && !found && req[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        grant_idx   = ID_W'(cand);
      end
    end
  end

endmodule

// File: rtl/logic_eval_scheduler.sv
// Shares one combinational 3-input evaluator among NUM_REQ requesters:
// round-robin accept, hold the vector for SETTLE_CYCLES, sample y, and
// return it on a valid/ready channel tagged with the requester id.
module logic_eval_scheduler
  import logic_eval_pkg::*;
#(
  parameter int unsigned NUM_REQ       = 4,
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*ABC_W-1:0]   req_abc,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic [ABC_W-1:0]           eval_abc,
  input  logic                       eval_y,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [$clog2(NUM_REQ)-1:0] rsp_id,
  output logic [ABC_W-1:0]           rsp_abc,
  output logic                       rsp_y,
  output logic                       busy
);

  localparam int unsigned ID_W  = $clog2(NUM_REQ);
  localparam int unsigned CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  if (NUM_REQ < 2) begin : g_bad_num_req
    $error("NUM_REQ must be >= 2");
  end
  if (SETTLE_CYCLES < 1) begin : g_bad_settle
    $error("SETTLE_CYCLES must be >= 1");
  end

  state_t            state_q;
  logic [ID_W-1:0]   last_grant_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              arb_en;
  logic [NUM_REQ-1:0] grant;
  logic [ID_W-1:0]   grant_idx;
  logic [ABC_W-1:0]  win_abc;

  // Grants only in IDLE; gated by rst_n so nothing looks accepted during reset.
  assign arb_en    = (state_q == IDLE) && rst_n;
  assign req_ready = grant;
  assign busy      = (state_q != IDLE);

  rr_arbiter #(
    .NUM_REQ(NUM_REQ)
  ) u_arb (
    .req       (req_valid),
    .en        (arb_en),
    .last_grant(last_grant_q),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  // Select the winner's vector from the one-hot grant.
  always_comb begin
    win_abc = '0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      if (grant[i]) win_abc = req_abc[i*ABC_W +: ABC_W];
    end
  end

  // Scheduler FSM with registered evaluator drive and response outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_grant_q <= ID_W'(NUM_REQ - 1);
      cnt_q        <= '0;
      eval_abc     <= '0;
      rsp_valid    <= 1'b0;
      rsp_id       <= '0;
      rsp_abc      <= '0;
      rsp_y        <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (|grant) begin
            eval_abc     <= win_abc;
            rsp_abc      <= win_abc;
            rsp_id       <= grant_idx;
            last_grant_q <= grant_idx;
            cnt_q        <= CNT_W'(SETTLE_CYCLES - 1);
            state_q      <= SETTLE;
          end
        end
        SETTLE: begin
          if (cnt_q == '0) begin
            rsp_y     <= eval_y;
            rsp_valid <= 1'b1;
            state_q   <= RESP;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state_q   <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_logic_eval_scheduler.sv
// Self-checking bench for logic_eval_scheduler: scoreboard of expected
// responses, a vector table, and hand sequences for arbitration,
// backpressure and mid-operation reset.
module tb_logic_eval_scheduler;

  localparam int NR = 4;
  localparam int SC = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [11:0] req_abc;
  logic [3:0]  req_ready;
  logic [2:0]  eval_abc;
  logic        eval_y;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [1:0]  rsp_id;
  logic [2:0]  rsp_abc;
  logic        rsp_y;
  logic        busy;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  typedef struct {
    logic [1:0] id;
    logic [2:0] abc;
    logic       y;
  } rsp_t;

  typedef struct {
    int         id;
    logic [2:0] abc;
    logic       y;
  } vec_t;

  rsp_t exp_q[$];
  vec_t vecs[10];

  // Evaluator model: true for {a,b,c} = 000, 100, 101.
  function automatic logic eval_fn(input logic [2:0] v);
    return (v == 3'b000) || (v == 3'b100) || (v == 3'b101);
  endfunction

  assign eval_y = eval_fn(eval_abc);

  logic_eval_scheduler #(
    .NUM_REQ      (NR),
    .SETTLE_CYCLES(SC)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_valid(req_valid),
    .req_abc  (req_abc),
    .req_ready(req_ready),
    .eval_abc (eval_abc),
    .eval_y   (eval_y),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_id   (rsp_id),
    .rsp_abc  (rsp_abc),
    .rsp_y    (rsp_y),
    .busy     (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_rsp_valid"}, 32'(rsp_valid), 0);
    check({tag, "_rsp_id"},    32'(rsp_id),    0);
    check({tag, "_rsp_abc"},   32'(rsp_abc),   0);
    check({tag, "_rsp_y"},     32'(rsp_y),     0);
    check({tag, "_busy"},      32'(busy),      0);
    check({tag, "_eval_abc"},  32'(eval_abc),  0);
    check({tag, "_req_ready"}, 32'(req_ready), 0);
  endtask

  // Response monitor: pops the scoreboard on every handshake.
  always @(negedge clk) begin
    if (rst_n) begin
      if (busy) check("ready_outside_idle", 32'(req_ready), 0);
      if (rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL rsp_unexpected: got id=%0d abc=%0b expected no response", rsp_id, rsp_abc);
        end else begin
          rsp_t e;
          e = exp_q.pop_front();
          check("rsp_id",  32'(rsp_id),  32'(e.id));
          check("rsp_abc", 32'(rsp_abc), 32'(e.abc));
          check("rsp_y",   32'(rsp_y),   32'(e.y));
        end
      end
    end
  end

  task automatic wait_ready(output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (req_ready != 0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("grant_timeout", 0, 1);
  endtask

  task automatic wait_rsp(output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (rsp_valid) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("rsp_timeout", 0, 1);
  endtask

  task automatic drain();
    bit done;
    done = 1'b0;
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !busy) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) check("drain_timeout", 32'(exp_q.size()), 0);
    @(posedge clk);
    #1;
  endtask

  // Raise one request, check the grant, optionally queue the expected response.
  task automatic issue(input int id, input logic [2:0] abc, input logic y, input bit push,
                       input bit hold, output int acc);
    bit   ok;
    rsp_t e;
    req_abc[id*3 +: 3] = abc;
    req_valid[id]      = 1'b1;
    wait_ready(ok);
    acc = cyc + 1;
    if (ok) begin
      check("req_ready", 32'(req_ready), 32'(1) << id);
      if (push) begin
        e.id  = 2'(id);
        e.abc = abc;
        e.y   = y;
        exp_q.push_back(e);
      end
    end
    @(posedge clk);
    #1;
    if (!hold) req_valid[id] = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit         ok;
    int         acc, prev, ptr, exp_id;
    rsp_t       e;
    logic [7:0] y_tab;
    logic [2:0] rr_abc[4];
    logic       rr_y[4];

    vecs[0] = '{1, 3'b100, 1'b1};
    vecs[1] = '{1, 3'b010, 1'b0};
    y_tab   = 8'b0011_0001;
    for (int v = 0; v < 8; v++) begin
      vecs[2+v].id  = 2;
      vecs[2+v].abc = 3'(v);
      vecs[2+v].y   = y_tab[v];
    end
    rr_abc = '{3'b000, 3'b011, 3'b101, 3'b110};
    rr_y   = '{1'b1, 1'b0, 1'b1, 1'b0};

    rst_n     = 1'b0;
    req_valid = '0;
    req_abc   = '0;
    rsp_ready = 1'b0;
    #1;
    check_zero("reset");
    repeat (3) @(posedge clk);
    #3;
    rst_n = 1'b1;

    // All four requesting continuously: 0,1,2,3,0 spaced SC+2 apart.
    rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) req_abc[i*3 +: 3] = rr_abc[i];
    req_valid = 4'hF;
    ptr  = NR - 1;
    prev = 0;
    for (int k = 0; k < 5; k++) begin
      exp_id = (ptr + 1) % NR;
      ptr    = exp_id;
      wait_ready(ok);
      if (!ok) break;
      check("rr_grant", 32'(req_ready), 32'(1) << exp_id);
      e.id  = 2'(exp_id);
      e.abc = rr_abc[exp_id];
      e.y   = rr_y[exp_id];
      exp_q.push_back(e);
      acc = cyc + 1;
      if (k > 0) check("rr_spacing", 32'(acc - prev), SC + 2);
      prev = acc;
      @(posedge clk);
      #1;
    end
    req_valid = '0;
    drain();

    // Vector table: requester 1 then requester 2 sweep.
    for (int i = 0; i < 10; i++) begin
      issue(vecs[i].id, vecs[i].abc, vecs[i].y, 1'b1, 1'b0, acc);
      wait_rsp(ok);
      if (ok) begin
        check("rsp_latency", 32'(cyc - acc), SC);
        check("eval_abc_hold", 32'(eval_abc), 32'(vecs[i].abc));
      end
      drain();
    end

    // Backpressure in RESP with another requester waiting.
    rsp_ready = 1'b0;
    issue(3, 3'b110, 1'b0, 1'b1, 1'b0, acc);
    wait_rsp(ok);
    req_abc[2:0] = 3'b001;
    req_valid[0] = 1'b1;
    for (int k = 0; k < 5; k++) begin
      check("bp_rsp_valid", 32'(rsp_valid), 1);
      check("bp_rsp_id",    32'(rsp_id),    3);
      check("bp_rsp_abc",   32'(rsp_abc),   32'(3'b110));
      check("bp_rsp_y",     32'(rsp_y),     0);
      check("bp_busy",      32'(busy),      1);
      check("bp_req_ready", 32'(req_ready), 0);
      if (k < 4) @(negedge clk);
    end
    @(posedge clk);
    #1;
    rsp_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("bp_next_grant", 32'(req_ready), 32'(4'b0001));
    check("bp_idle", 32'(busy), 0);
    e.id  = 2'd0;
    e.abc = 3'b001;
    e.y   = 1'b0;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    req_valid[0] = 1'b0;
    drain();

    // Reset during SETTLE: response dropped, request re-served.
    rsp_ready = 1'b1;
    issue(1, 3'b101, 1'b1, 1'b0, 1'b1, acc);
    #3;
    rst_n = 1'b0;
    #1;
    check_zero("rst_settle");
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    wait_ready(ok);
    check("rst_settle_reserve", 32'(req_ready), 32'(4'b0010));
    e.id  = 2'd1;
    e.abc = 3'b101;
    e.y   = 1'b1;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    req_valid[1] = 1'b0;
    drain();

    // Reset during RESP: pending response discarded.
    rsp_ready = 1'b0;
    issue(2, 3'b111, 1'b0, 1'b0, 1'b1, acc);
    wait_rsp(ok);
    #2;
    rst_n = 1'b0;
    #1;
    check_zero("rst_resp");
    @(posedge clk);
    #3;
    rst_n     = 1'b1;
    rsp_ready = 1'b1;
    wait_ready(ok);
    check("rst_resp_reserve", 32'(req_ready), 32'(4'b0100));
    e.id  = 2'd2;
    e.abc = 3'b111;
    e.y   = 1'b0;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    req_valid[2] = 1'b0;
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
